// File: rtl/instruction_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_ctrl_if
//   Bundles the fetch controller's bus-side signals: the instruction memory
//   port, the redirect/halt controls from the PC/branch logic, and the
//   valid/ready handshake towards decode.
//
//   Signals
//     imem_sel        fetch byte address to instruction memory
//     imem_data       instruction word at imem_sel (same cycle)
//     redirect_valid  branch/jump taken this cycle
//     redirect_pc     redirect target byte address
//     halt            level; suspends fetching
//     out_valid       queue head valid
//     out_instr       head instruction (0 when not valid)
//     out_pc          head PC (0 when not valid)
//     out_ready       decode accepts the head entry
//     fault           sticky misaligned-redirect flag
//
//   Modports
//     master  the fetch controller itself
//     slave   the surroundings (memory, branch logic, decode)
// -----------------------------------------------------------------------------
interface instruction_fetch_ctrl_if;
    logic [31:0] imem_sel;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic        fault;

    modport master (
        output imem_sel,
        output out_valid,
        output out_instr,
        output out_pc,
        output fault,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        input  out_ready
    );

    modport slave (
        input  imem_sel,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  fault,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        output halt,
        output out_ready
    );
endinterface

// File: rtl/instruction_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instruction_fetch_ctrl
//   Owns the fetch PC, addresses the combinational instruction memory and
//   queues fetched {pc, instr} pairs in order for the decode stage. Taken
//   branches/jumps flush the queue and reload the PC; halt stops fetching
//   while the queue keeps draining.
//
//   Parameters
//     RESET_PC    fetch address after reset (word aligned)
//     FIFO_DEPTH  queue entries (power of two, >= 2)
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     bus    instruction_fetch_ctrl_if.master (memory, redirect, decode)
//
//   Build option
//     IFETCH_ALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned
//                            target raises fault and parks the fetcher in
//                            FAULT until reset. When undefined, fault is 0
//                            and the target's low two bits are cleared.
// -----------------------------------------------------------------------------
module instruction_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_ctrl_if.master  bus
);

    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [PTR_W:0]     count_q;
    logic [31:0]        pc_mem    [FIFO_DEPTH];
    logic [31:0]        instr_mem [FIFO_DEPTH];

    logic               head_valid;
    logic               push;
    logic               pop;
    logic               flush;
    logic               misaligned;
    logic [31:0]        aligned_target;

    assign head_valid    = (count_q != '0);
    assign pop           = head_valid & bus.out_ready;
    assign bus.imem_sel  = fetch_pc_q;
    assign bus.out_valid = head_valid;
    assign bus.out_pc    = head_valid ? pc_mem[head_q]    : 32'd0;
    assign bus.out_instr = head_valid ? instr_mem[head_q] : 32'd0;

    // Without the alignment check the low bits are simply dropped.
    assign aligned_target = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = (bus.redirect_pc[1:0] != 2'b00);
    assign bus.fault  = (state_q == FAULT);
`else
    assign misaligned = 1'b0;
    assign bus.fault  = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;

        case (state_q)
            FETCH, HALT: begin
                if (bus.redirect_valid) begin
                    // Redirect beats push and halt; a same-cycle pop has
                    // already been handed to decode and stays delivered.
                    flush = 1'b1;
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        fetch_pc_d = aligned_target;
                        state_d    = bus.halt ? HALT : FETCH;
                    end
                end else begin
                    // A pop frees the head slot this cycle, so a full queue
                    // can still accept a new entry (one instr per cycle).
                    if (state_q == FETCH && (count_q < DEPTH_CNT || pop)) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    state_d = bus.halt ? HALT : FETCH;
                end
            end
            FAULT: begin
                // Parked until reset; keep the queue empty.
                flush = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (pop)  head_q <= head_q + 1'b1;
                if (push) tail_q <= tail_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // NOTE: the entry storage is not reset; count_q gates every read, so
    // stale contents are never visible and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_q]    <= fetch_pc_q;
            instr_mem[tail_q] <= bus.imem_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_ctrl
//   Self-checking bench for instruction_fetch_ctrl (RESET_PC=0, FIFO_DEPTH=2).
//   Instruction memory model: word at address a is a + 32'h100.
//   Directed scenarios compare against fixed expected values; the random
//   scenario compares against a queue-based reference model.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_ctrl;

    localparam logic [31:0] RESET_PC   = 32'd0;
    localparam int          FIFO_DEPTH = 2;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_ctrl_if bus ();

    instruction_fetch_ctrl #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_data = bus.imem_sel + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc     = RESET_PC;
    bit          m_halted = 1'b0;
    bit          m_fault  = 1'b0;

    // One clock edge of the fetch unit, described as queue operations.
    task automatic model_step();
        entry_t e;
        if (reset) begin
            mq.delete();
            m_pc     = RESET_PC;
            m_halted = 1'b0;
            m_fault  = 1'b0;
        end else if (m_fault) begin
            mq.delete();
        end else begin
            if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
            if (bus.redirect_valid) begin
                mq.delete();
                if (ALIGN_CHECK && bus.redirect_pc[1:0] != 2'b00)
                    m_fault = 1'b1;
                else
                    m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else if (!m_halted && mq.size() < FIFO_DEPTH) begin
                e.pc    = m_pc;
                e.instr = m_pc + 32'h100;
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            m_halted = bus.halt;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.out_ready      = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        // Reset must win over a redirect, halt and ready in the same cycle.
        reset              = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.halt           = 1'b1;
        bus.out_ready      = 1'b1;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected 0", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.out_instr); end
        checks++; if (bus.imem_sel !== RESET_PC) begin errors++; $display("FAIL reset_sel: got %h expected %h", bus.imem_sel, RESET_PC); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
        bus.redirect_valid = 1'b0;
        bus.halt           = 1'b0;
        reset              = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready = 1'b1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_pre_valid: got %b expected 0", bus.out_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            checks++; if (bus.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, bus.out_pc, 32'(4 * i)); end
            checks++; if (bus.out_instr !== 32'(4 * i + 'h100)) begin errors++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, bus.out_instr, 32'(4 * i + 'h100)); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (5) tick();
        checks++; if (bus.out_pc !== 32'd0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=0", bus.out_valid, bus.out_pc); end
        checks++; if (bus.imem_sel !== 32'd8) begin errors++; $display("FAIL bp_sel_frozen: got %h expected 8", bus.imem_sel); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * i)) begin errors++; $display("FAIL bp_drain[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, bus.out_valid, bus.out_pc, 32'(4 * i)); end
            tick();
        end
    endtask

    task automatic test_redirect_flush();
        do_reset();
        repeat (3) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd24;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.imem_sel !== 32'd24) begin errors++; $display("FAIL redir_sel: got %h expected 24", bus.imem_sel); end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_pc !== 32'd24 || bus.out_instr !== 32'h118) begin errors++; $display("FAIL redir_first: got pc=%h instr=%h expected pc=18 instr=118", bus.out_pc, bus.out_instr); end
        tick();
        checks++; if (bus.out_pc !== 32'd28) begin errors++; $display("FAIL redir_second: got %h expected 1c", bus.out_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL wrap_gap: got %b expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_pc !== 32'hFFFF_FFFC || bus.out_instr !== 32'h0000_00FC) begin errors++; $display("FAIL wrap_top: got pc=%h instr=%h expected pc=fffffffc instr=fc", bus.out_pc, bus.out_instr); end
        checks++; if (bus.imem_sel !== 32'd0) begin errors++; $display("FAIL wrap_sel: got %h expected 0", bus.imem_sel); end
        tick();
        checks++; if (bus.out_pc !== 32'd0 || bus.out_instr !== 32'h100) begin errors++; $display("FAIL wrap_zero: got pc=%h instr=%h expected pc=0 instr=100", bus.out_pc, bus.out_instr); end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (3) tick();
        bus.halt = 1'b1;
        tick();
        bus.out_ready = 1'b1;
        checks++; if (bus.out_pc !== 32'd0) begin errors++; $display("FAIL halt_head0: got %h expected 0", bus.out_pc); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd4) begin errors++; $display("FAIL halt_head1: got valid=%b pc=%h expected valid=1 pc=4", bus.out_valid, bus.out_pc); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b0 || bus.imem_sel !== 32'd8) begin errors++; $display("FAIL halt_idle[%0d]: got valid=%b sel=%h expected valid=0 sel=8", i, bus.out_valid, bus.imem_sel); end
        end
        bus.halt = 1'b0;
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_exit_gap: got %b expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_pc !== 32'd8) begin errors++; $display("FAIL halt_resume: got %h expected 8", bus.out_pc); end
        tick();
        checks++; if (bus.out_pc !== 32'd12) begin errors++; $display("FAIL halt_resume2: got %h expected c", bus.out_pc); end
        reset = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_sel !== 32'd0) begin errors++; $display("FAIL midreset: got valid=%b sel=%h expected valid=0 sel=0", bus.out_valid, bus.imem_sel); end
        reset = 1'b0;
        tick();
        checks++; if (bus.out_pc !== 32'd0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_restart: got valid=%b pc=%h expected valid=1 pc=0", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_misaligned();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (2) tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd26;
        tick();
        bus.redirect_valid = 1'b0;
        if (ALIGN_CHECK) begin
            checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mis_fault: got fault=%b valid=%b expected fault=1 valid=0", bus.fault, bus.out_valid); end
            for (int i = 0; i < 4; i++) begin
                bus.redirect_valid = (i == 1);
                bus.redirect_pc    = 32'd40;
                tick();
                checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL mis_stuck[%0d]: got fault=%b valid=%b expected fault=1 valid=0", i, bus.fault, bus.out_valid); end
            end
            do_reset();
            checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL mis_clear: got %b expected 0", bus.fault); end
        end else begin
            checks++; if (bus.fault !== 1'b0 || bus.imem_sel !== 32'd24) begin errors++; $display("FAIL mis_align: got fault=%b sel=%h expected fault=0 sel=18", bus.fault, bus.imem_sel); end
            tick();
            checks++; if (bus.out_pc !== 32'd24 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mis_resume: got valid=%b pc=%h expected valid=1 pc=18", bus.out_valid, bus.out_pc); end
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [31:0] exp_pc, exp_instr;
        bit          exp_valid;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset         = ($urandom_range(0, 59) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) bus.halt = ~bus.halt;
            bus.redirect_valid = ($urandom_range(0, 9) == 0);
            r = $urandom();
            if ($urandom_range(0, 15) != 0) r[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF8;
            bus.redirect_pc = r;
            tick();
            exp_valid = (mq.size() != 0);
            exp_pc    = exp_valid ? mq[0].pc    : 32'd0;
            exp_instr = exp_valid ? mq[0].instr : 32'd0;
            checks++; if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", n, bus.out_valid, exp_valid); end
            checks++; if (bus.out_pc !== exp_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h expected %h", n, bus.out_pc, exp_pc); end
            checks++; if (bus.out_instr !== exp_instr) begin errors++; $display("FAIL rnd_instr@%0d: got %h expected %h", n, bus.out_instr, exp_instr); end
            checks++; if (bus.imem_sel !== m_pc) begin errors++; $display("FAIL rnd_sel@%0d: got %h expected %h", n, bus.imem_sel, m_pc); end
            checks++; if (bus.fault !== m_fault) begin errors++; $display("FAIL rnd_fault@%0d: got %b expected %b", n, bus.fault, m_fault); end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.out_ready      = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_wrap();
        test_halt();
        test_misaligned();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
